rename_free_list_ctrl: RTL and testbench

RENAME_FREE_LIST_CTRL -- requirements
Module: rename_free_list_ctrl

---
 rtl/rename_free_list_ctrl.sv | 131 +++++++++++++
 tb/tb_rename_free_list_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_free_list_ctrl.sv
// Physical-register free list for rename: circular FIFO of tags NUM_ARCH..NUM_PHYS-1, rebuilt on reset/flush.
// Optional FREELIST_BYPASS_EN: on an empty list a same-cycle release is forwarded straight to the allocator.
module rename_free_list_ctrl #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    parameter int TAG_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_req,
    output logic             alloc_grant,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             rel_valid,
    input  logic [TAG_W-1:0] rel_tag,
    output logic [TAG_W-1:0] free_count,
    output logic             ready,
    output logic             rel_err
);

    localparam int D  = NUM_PHYS - NUM_ARCH;
    localparam int PW = $clog2(D);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [TAG_W-1:0] ARCH_TAG = TAG_W'(NUM_ARCH);
    localparam logic [TAG_W-1:0] FULL_CNT = TAG_W'(D);
    localparam logic [PW-1:0]    LAST_IDX = PW'(D - 1);

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [TAG_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] mem_q [D];

    logic run, tag_ok, empty, full;
    logic grant_fifo, bypass, rel_accept, rel_drop;

    assign run    = (state_q == ST_RUN);
    assign tag_ok = (rel_tag >= ARCH_TAG);
    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);

    assign grant_fifo = run && !flush && alloc_req && !empty;

`ifdef FREELIST_BYPASS_EN
    assign bypass = run && !flush && empty && alloc_req && rel_valid && tag_ok;
`else
    assign bypass = 1'b0;
`endif

    // A release into a full list is still legal when a grant frees a slot the same cycle.
    assign rel_accept = run && !flush && rel_valid && tag_ok && (!full || grant_fifo) && !bypass;
    assign rel_drop   = run && !flush && rel_valid && !rel_accept && !bypass;

    always_comb begin
        alloc_tag = '0;
        if (bypass) begin
            alloc_tag = rel_tag;
        end else if (grant_fifo) begin
            alloc_tag = mem_q[head_q];
        end
    end

    assign alloc_grant = grant_fifo | bypass;
    assign ready       = run;
    assign free_count  = count_q;
    assign rel_err     = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            state_d = ST_INIT;
            idx_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (state_q == ST_INIT) begin
            idx_d   = idx_q + 1'b1;
            count_d = count_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = ST_RUN;
                head_d  = '0;
                tail_d  = '0;
            end
        end else begin
            head_d  = head_q + PW'(grant_fifo);
            tail_d  = tail_q + PW'(rel_accept);
            count_d = count_q + TAG_W'(rel_accept) - TAG_W'(grant_fifo);
            err_d   = err_q | rel_drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage is never reset: INIT rewrites every entry before RUN can read it.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (state_q == ST_INIT) begin
                mem_q[idx_q] <= ARCH_TAG + TAG_W'(idx_q);
            end else if (rel_accept) begin
                mem_q[tail_q] <= rel_tag;
            end
        end
    end

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Self-checking bench for rename_free_list_ctrl against a queue-based free-list model.
module tb_rename_free_list_ctrl;

    localparam int NA = 32;
    localparam int NP = 64;
    localparam int TW = 6;
    localparam int D  = NP - NA;

    logic          clk = 1'b0;
    logic          reset, flush, alloc_req, rel_valid;
    logic [TW-1:0] rel_tag;
    logic          alloc_grant, ready, rel_err;
    logic [TW-1:0] alloc_tag, free_count;

    int errors = 0;
    int checks = 0;

    int q[$];
    bit m_ready;
    int m_init;
    bit m_err;

    always #5 clk = ~clk;

    rename_free_list_ctrl #(.NUM_ARCH(NA), .NUM_PHYS(NP), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_tag(alloc_tag),
        .rel_valid(rel_valid), .rel_tag(rel_tag),
        .free_count(free_count), .ready(ready), .rel_err(rel_err)
    );

    task automatic model_reset();
        q.delete();
        m_ready = 0;
        m_init  = 0;
        m_err   = 0;
    endtask

    task automatic model_out(output bit g, output int t);
        g = 0;
        t = 0;
        if (m_ready && !flush) begin
            if (alloc_req && q.size() > 0) begin
                g = 1;
                t = q[0];
            end
`ifdef FREELIST_BYPASS_EN
            else if (alloc_req && q.size() == 0 && rel_valid && int'(rel_tag) >= NA) begin
                g = 1;
                t = int'(rel_tag);
            end
`endif
        end
    endtask

    // Advance one clock and apply the free-list rules to the model.
    task automatic tick();
        bit g;
        int t;
        bit byp;
        model_out(g, t);
        @(posedge clk);
        if (flush) begin
            q.delete();
            m_ready = 0;
            m_init  = 0;
        end else if (!m_ready) begin
            q.push_back(NA + m_init);
            m_init++;
            if (m_init == D) m_ready = 1;
        end else begin
            byp = g && q.size() == 0;
            if (g && !byp) void'(q.pop_front());
            if (rel_valid && !byp) begin
                if (int'(rel_tag) >= NA && q.size() < D) q.push_back(int'(rel_tag));
                else m_err = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush     = 0;
        alloc_req = 0;
        rel_valid = 0;
        rel_tag   = '0;
    endtask

    task automatic do_init();
        reset = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 0;
        repeat (D) tick();
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        alloc_req = 1;
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({ready, alloc_grant, rel_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got ready/grant/err=%b%b%b want 000", ready, alloc_grant, rel_err);
        end
        checks++;
        if (alloc_tag !== '0 || free_count !== '0) begin
            errors++;
            $display("FAIL reset_vals: got tag=%0d count=%0d want 0 0", alloc_tag, free_count);
        end
    endtask

    task automatic test_init();
        bit ok_ready = 1;
        bit ok_cnt = 1;
        reset = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 0;
        alloc_req = 1;
        for (int i = 0; i < D; i++) begin
            #1;
            if (ready !== 1'b0 || alloc_grant !== 1'b0) ok_ready = 0;
            if (int'(free_count) != i) ok_cnt = 0;
            tick();
        end
        checks++;
        if (!ok_ready) begin
            errors++;
            $display("FAIL init_not_ready: got ready or grant high during INIT want 0");
        end
        checks++;
        if (!ok_cnt) begin
            errors++;
            $display("FAIL init_count: got non-incrementing free_count want 0..%0d", D - 1);
        end
        #1;
        checks++;
        if (ready !== 1'b1 || free_count !== TW'(D)) begin
            errors++;
            $display("FAIL init_done: got ready=%b count=%0d want 1 %0d", ready, free_count, D);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (alloc_grant !== 1'b1 || int'(alloc_tag) != NA + i) begin
                errors++;
                $display("FAIL init_first_tags: got grant=%b tag=%0d want 1 %0d", alloc_grant, alloc_tag, NA + i);
            end
            tick();
            #1;
        end
    endtask

    task automatic test_drain();
        do_init();
        alloc_req = 1;
        for (int i = 0; i <= D; i++) begin
            #1;
            checks++;
            if (i < D && (alloc_grant !== 1'b1 || int'(alloc_tag) != NA + i)) begin
                errors++;
                $display("FAIL drain_grant: got grant=%b tag=%0d want 1 %0d", alloc_grant, alloc_tag, NA + i);
            end else if (i == D && alloc_grant !== 1'b0) begin
                errors++;
                $display("FAIL drain_empty: got grant=%b want 0", alloc_grant);
            end
            tick();
        end
        #1;
        checks++;
        if (free_count !== '0) begin
            errors++;
            $display("FAIL drain_count: got %0d want 0", free_count);
        end
    endtask

    // Expects an empty list from test_drain.
    task automatic test_empty_release();
        alloc_req = 1;
        rel_valid = 1;
        rel_tag   = TW'(40);
        #1;
`ifdef FREELIST_BYPASS_EN
        checks++;
        if (alloc_grant !== 1'b1 || alloc_tag !== TW'(40)) begin
            errors++;
            $display("FAIL bypass_grant: got grant=%b tag=%0d want 1 40", alloc_grant, alloc_tag);
        end
        tick();
        rel_valid = 0;
        #1;
        checks++;
        if (free_count !== '0) begin
            errors++;
            $display("FAIL bypass_count: got %0d want 0", free_count);
        end
`else
        checks++;
        if (alloc_grant !== 1'b0) begin
            errors++;
            $display("FAIL empty_grant: got %b want 0", alloc_grant);
        end
        tick();
        rel_valid = 0;
        #1;
        checks++;
        if (free_count !== TW'(1) || alloc_grant !== 1'b1 || alloc_tag !== TW'(40)) begin
            errors++;
            $display("FAIL empty_enqueue: got count=%0d grant=%b tag=%0d want 1 1 40", free_count, alloc_grant, alloc_tag);
        end
        tick();
`endif
        idle_inputs();
    endtask

    task automatic test_drop();
        do_init();
        rel_valid = 1;
        rel_tag   = TW'(50);
        tick();
        rel_valid = 0;
        #1;
        checks++;
        if (rel_err !== 1'b1 || free_count !== TW'(D)) begin
            errors++;
            $display("FAIL drop_full: got err=%b count=%0d want 1 %0d", rel_err, free_count, D);
        end
        alloc_req = 1;
        repeat (D - 10) tick();
        alloc_req = 0;
        rel_valid = 1;
        rel_tag   = TW'(5);
        tick();
        rel_valid = 0;
        repeat (3) tick();
        #1;
        checks++;
        if (rel_err !== 1'b1 || free_count !== TW'(10)) begin
            errors++;
            $display("FAIL drop_arch: got err=%b count=%0d want 1 10", rel_err, free_count);
        end
        reset = 1;
        #1;
        checks++;
        if (rel_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", rel_err);
        end
        reset = 0;
    endtask

    task automatic test_back_to_back();
        int exp_tag;
        do_init();
        for (int k = 0; k < 40; k++) begin
            alloc_req = 1;
            rel_valid = 1;
            rel_tag   = TW'(63 - (k % 32));
            #1;
            exp_tag = (k < D) ? NA + k : 63 - (k - D);
            checks++;
            if (alloc_grant !== 1'b1 || int'(alloc_tag) != exp_tag || free_count !== TW'(D)) begin
                errors++;
                $display("FAIL b2b_%0d: got grant=%b tag=%0d count=%0d want 1 %0d %0d", k, alloc_grant, alloc_tag, free_count, exp_tag, D);
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (rel_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err: got %b want 0", rel_err);
        end
    endtask

    task automatic test_flush();
        do_init();
        alloc_req = 1;
        repeat (D - 7) tick();
        flush = 1;
        #1;
        checks++;
        if (alloc_grant !== 1'b0 || free_count !== TW'(7)) begin
            errors++;
            $display("FAIL flush_cycle: got grant=%b count=%0d want 0 7", alloc_grant, free_count);
        end
        tick();
        flush = 0;
        #1;
        checks++;
        if (ready !== 1'b0 || free_count !== '0) begin
            errors++;
            $display("FAIL flush_next: got ready=%b count=%0d want 0 0", ready, free_count);
        end
        // Flush mid-INIT restarts the full rebuild.
        repeat (5) tick();
        flush = 1;
        tick();
        flush = 0;
        repeat (D - 1) tick();
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_restart: got ready=%b want 0", ready);
        end
        tick();
        #1;
        checks++;
        if (ready !== 1'b1 || alloc_grant !== 1'b1 || alloc_tag !== TW'(NA)) begin
            errors++;
            $display("FAIL flush_reinit: got ready=%b grant=%b tag=%0d want 1 1 %0d", ready, alloc_grant, alloc_tag, NA);
        end
        flush = 1;
        tick();
        flush = 0;
        repeat (12) tick();
        reset = 1;
        #1;
        checks++;
        if ({ready, alloc_grant, rel_err} !== 3'b000 || alloc_tag !== '0 || free_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_init: got ready=%b grant=%b tag=%0d count=%0d want all 0", ready, alloc_grant, alloc_tag, free_count);
        end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_random();
        bit g;
        int t;
        int bad = 0;
        do_init();
        for (int n = 0; n < 600; n++) begin
            alloc_req = ($urandom_range(0, 99) < 55);
            rel_valid = ($urandom_range(0, 99) < 50);
            rel_tag   = TW'($urandom_range(NA - 4, NP - 1));
            flush     = ($urandom_range(0, 199) == 0);
            #1;
            model_out(g, t);
            checks++;
            if (alloc_grant !== g || int'(alloc_tag) != t || int'(free_count) != q.size()
                || ready !== m_ready || rel_err !== m_err) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_%0d: got g=%b t=%0d c=%0d r=%b e=%b want %b %0d %0d %b %b",
                             n, alloc_grant, alloc_tag, free_count, ready, rel_err, g, t, q.size(), m_ready, m_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_init();
        test_drain();
        test_empty_release();
        test_drop();
        test_back_to_back();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
